apb_cmd_bridge: RTL and testbench
=================================

Name: apb_cmd_bridge

Overview:
- Synthesizable APB3 requester that replaces the bench's task-driven APB master.
- Accepts read/write commands on a valid/ready interface and buffers them in a small FIFO.
- Issues each command as an APB SETUP/ACCESS transfer to the downstream APB slave, then returns a one-cycle response carrying the read data and an error flag.

Parameters:
ADDR_W, 4, APB address width
DATA_W, 8, APB data width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 16, max ACCESS cycles with pready low before forced termination; 0 disables timeout

Ports:
pclk  in  1  APB clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  command address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse per completed command
rsp_write  out  1  type of the completed command
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  1  transfer terminated by timeout
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
psel  out  1  APB select
penable  out  1  APB enable
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready

Behaviour:
- Interface decision: one clock (pclk); reset rst is asynchronous and active-high.
- Reset values: all outputs 0 except cmd_ready=1; FIFO empty; FSM in IDLE.
- Command FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full, registered from occupancy count, with no combinational path from cmd_valid.
  - Pop occurs on the edge the FSM enters SETUP. Push and pop in the same cycle are both honoured and leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The count is FIFO_DEPTH+1 states wide.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: psel=0, penable=0. If the FIFO is non-empty, load paddr/pwrite/pwdata from the FIFO head, pop, and go to SETUP.
  - SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS.
  - ACCESS: psel=1, penable=1. Stay while pready=0 and the timeout has not expired.
  - ACCESS completion: when pready=1 is sampled, complete normally. Capture prdata into rsp_rdata if a read, otherwise 0. Set rsp_err=0.
  - Completion then goes to SETUP, loading and popping the next command, if the FIFO is non-empty. Otherwise go to IDLE with psel=0 and penable=0.
- Back-to-back transfers: psel stays high across transfers and penable drops for the SETUP cycle. The bus carries no idle cycle between queued commands.
- Timeout:
  - The wait counter clears on SETUP entry and increments each ACCESS cycle in which pready=0.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT while pready is still 0, complete with rsp_err=1 and rsp_rdata=0, then advance as on normal completion.
  - pready=1 on the same cycle the counter hits TIMEOUT counts as normal completion (pready wins).
- Response:
  - rsp_valid is high for exactly the cycle after the completing edge, with no backpressure.
  - rsp_write, rsp_rdata and rsp_err are registered together with rsp_valid and hold until the next response.
- Address and data hold: paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS, and hold their last value in IDLE.
- Latency:
  - Command pushed at edge N into an empty IDLE bridge: SETUP follows edge N+1 and ACCESS follows N+2.
  - With pready=1, completion is at edge N+3 and rsp_valid is high after N+3.
  - Each pready=0 wait cycle adds one cycle.
- Reset mid-operation: asynchronously drops psel, penable and rsp_valid, flushes the FIFO, and discards the in-flight transfer with no response.

Test Plan:
- Write addr=2 data=5 with pready tied 1 -> psel high 2 cycles, penable high 1 cycle with paddr=2, pwdata=5, pwrite=1; rsp_valid pulse with rsp_write=1, rsp_err=0, 3 cycles after acceptance.
- Read addr=3, slave returns prdata=10 after 2 wait cycles -> ACCESS lasts 3 cycles; rsp_rdata=10, rsp_write=0, rsp_err=0.
- Push writes (2,5),(3,10) and reads (2),(3) back-to-back -> psel continuously high, penable low for one SETUP cycle between transfers; four rsp_valid pulses in order; reads return 5 and 10.
- Hold pready=0 and push 5 commands -> cmd_ready deasserts after 4 FIFO entries plus 1 in flight, i.e. low once the FIFO holds 4.
- Same setup, TIMEOUT=16 -> the first transfer ends after 16 ACCESS cycles with rsp_err=1 and rsp_rdata=0, and the next command starts.
- Assert rst during ACCESS with the FIFO holding 2 commands -> psel and penable go 0 without waiting for a clock edge, cmd_ready=1, no rsp_valid; after release the bus stays idle until a new command arrives.

Source files
------------

// File: rtl/apb_cmd_bridge_if.sv
// Command, response and APB signals of the command bridge, grouped for module ports.
// valid/ready: a command transfers on a rising edge where cmd_valid && cmd_ready; rsp_valid is a one-cycle pulse with no backpressure.
interface apb_cmd_bridge_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
               paddr, pwrite, psel, penable, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
               paddr, pwrite, psel, penable, pwdata
    );
endinterface

// File: rtl/apb_cmd_bridge.sv
// APB3 requester: queues read/write commands in a small FIFO and issues each as a
// SETUP/ACCESS transfer, returning a one-cycle response with read data and timeout flag.
module apb_cmd_bridge #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                 pclk,
    input  logic                 rst,
    apb_cmd_bridge_if.master     bus,
    output logic [1:0]           state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W  = 1 + ADDR_W + DATA_W;
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cmd_ready_q;

    state_t            state_q;
    logic              psel_q, penable_q, pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              rsp_valid_q, rsp_write_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              push, pop, done, timeout_hit;
    logic [ENT_W-1:0]  head;

    assign push        = bus.cmd_valid && cmd_ready_q;
    assign head        = mem_q[rd_ptr_q];
    // pready wins over a timeout expiring on the same cycle.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST) && !bus.pready;
    assign done        = (state_q == ACCESS) && (bus.pready || timeout_hit);
    assign pop         = (count_q != '0) && ((state_q == IDLE) || done);

    always_comb begin
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge pclk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            cmd_ready_q <= (count_d != FULL_CNT);
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        {pwrite_q, paddr_q, pwdata_q} <= head;
                        psel_q     <= 1'b1;
                        penable_q  <= 1'b0;
                        wait_cnt_q <= '0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= pwrite_q;
                        rsp_rdata_q <= (bus.pready && !pwrite_q) ? bus.prdata : '0;
                        rsp_err_q   <= !bus.pready;
                        penable_q   <= 1'b0;
                        // Chain straight into the next SETUP so psel never drops between queued commands.
                        if (pop) begin
                            {pwrite_q, paddr_q, pwdata_q} <= head;
                            wait_cnt_q <= '0;
                            state_q    <= SETUP;
                        end else begin
                            psel_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_apb_cmd_bridge.sv
// Self-checking bench for apb_cmd_bridge: table-driven single transfers, back-to-back
// streaming, timeout with a stalled slave, and asynchronous reset mid-transfer.
module tb_apb_cmd_bridge;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT = 16;
  localparam int RSP_W = 1 + DATA_W + 1;

  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] state_dbg;

  apb_cmd_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_cmd_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .bus(bus),
    .state_o(state_dbg)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // APB slave model with programmable wait states and a stall switch
  logic [7:0] slv_mem [16];
  int wait_cfg = 0;
  logic hold_low = 1'b0;
  int acc_cnt;

  assign bus.prdata = slv_mem[bus.paddr];
  assign bus.pready = bus.psel && bus.penable && !hold_low && (acc_cnt >= wait_cfg);

  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      acc_cnt <= 0;
      for (int i = 0; i < 16; i++) slv_mem[i] <= 8'h40 + 8'(i);
    end else begin
      if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (bus.psel && bus.penable && bus.pready && bus.pwrite) slv_mem[bus.paddr] <= bus.pwdata;
    end
  end

  // scoreboard
  int n_chk = 0;
  int n_err = 0;
  int rsp_cnt = 0;
  logic [RSP_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (!rst && bus.rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(1), 32'(0));
      end else begin
        logic [RSP_W-1:0] e;
        e = exp_q.pop_front();
        chk("rsp_fields", 32'({bus.rsp_write, bus.rsp_rdata, bus.rsp_err}), 32'(e));
      end
    end
  end

  // driver
  task automatic send(input logic w, input logic [3:0] a, input logic [7:0] d,
                      input logic [RSP_W-1:0] exp, output time t_acc);
    bit ok;
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr = a;
    bus.cmd_wdata = d;
    ok = 1'b0;
    t_acc = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.cmd_ready) begin
        @(posedge pclk);
        ok = 1'b1;
        t_acc = $time;
        break;
      end
      @(negedge pclk);
    end
    if (ok) exp_q.push_back(exp);
    else chk("send_accept", 32'(0), 32'(1));
    #1 bus.cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic w;
    logic [3:0] a;
    logic [7:0] d;
    int waits;
    logic [7:0] exp_rd;
  } vec_t;

  initial begin
    vec_t vecs[8];
    time t0, t1;
    int psel_n, pen_n, lat, seen, gaps, setup_n;
    bit bus_ok, started, got;

    vecs[0] = '{1'b1, 4'd2,  8'd5,   0, 8'h00};
    vecs[1] = '{1'b1, 4'd3,  8'd10,  2, 8'h00};
    vecs[2] = '{1'b0, 4'd3,  8'd0,   2, 8'd10};
    vecs[3] = '{1'b0, 4'd2,  8'd0,   0, 8'd5};
    vecs[4] = '{1'b1, 4'd15, 8'hA5,  1, 8'h00};
    vecs[5] = '{1'b0, 4'd15, 8'd0,   3, 8'hA5};
    vecs[6] = '{1'b0, 4'd0,  8'd0,   0, 8'h40};
    vecs[7] = '{1'b0, 4'd7,  8'd0,   1, 8'h47};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;

    // reset state
    repeat (2) @(negedge pclk);
    chk("rst_psel", 32'(bus.psel), 32'(0));
    chk("rst_penable", 32'(bus.penable), 32'(0));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    chk("rst_paddr", 32'(bus.paddr), 32'(0));
    chk("rst_state", 32'(state_dbg), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge pclk);

    // single transfers: latency, select/enable durations and bus contents
    for (int v = 0; v < 8; v++) begin
      wait_cfg = vecs[v].waits;
      send(vecs[v].w, vecs[v].a, vecs[v].d, {vecs[v].w, vecs[v].exp_rd, 1'b0}, t0);
      psel_n = 0; pen_n = 0; lat = 0; bus_ok = 1'b1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge pclk);
        if (bus.psel) psel_n++;
        if (bus.penable) begin
          pen_n++;
          if (bus.paddr !== vecs[v].a || bus.pwrite !== vecs[v].w ||
              (vecs[v].w && bus.pwdata !== vecs[v].d)) bus_ok = 1'b0;
        end
        if (bus.rsp_valid) begin
          lat = k;
          break;
        end
      end
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].waits + 4));
      chk($sformatf("v%0d_psel_cycles", v), 32'(psel_n), 32'(vecs[v].waits + 2));
      chk($sformatf("v%0d_penable_cycles", v), 32'(pen_n), 32'(vecs[v].waits + 1));
      chk($sformatf("v%0d_bus_hold", v), 32'(bus_ok), 32'(1));
    end

    // back-to-back stream: psel never drops, one SETUP per transfer
    wait_cfg = 0;
    seen = 0; gaps = 0; setup_n = 0; started = 1'b0;
    fork
      begin
        send(1'b1, 4'd2, 8'd5,  {1'b1, 8'd0,  1'b0}, t0);
        send(1'b1, 4'd3, 8'd10, {1'b1, 8'd0,  1'b0}, t0);
        send(1'b0, 4'd2, 8'd0,  {1'b0, 8'd5,  1'b0}, t0);
        send(1'b0, 4'd3, 8'd0,  {1'b0, 8'd10, 1'b0}, t0);
      end
      begin
        for (int k = 0; k < 60 && seen < 4; k++) begin
          @(negedge pclk);
          if (bus.rsp_valid) seen++;
          if (bus.psel) started = 1'b1;
          else if (started && seen < 4) gaps++;
          if (bus.psel && !bus.penable) setup_n++;
        end
      end
    join
    chk("b2b_responses", 32'(seen), 32'(4));
    chk("b2b_psel_gaps", 32'(gaps), 32'(0));
    chk("b2b_setup_cycles", 32'(setup_n), 32'(4));

    // stalled slave: FIFO fills, first transfer times out after TIMEOUT access cycles
    hold_low = 1'b1;
    send(1'b1, 4'd1, 8'd11,   {1'b1, 8'd0, 1'b1}, t1);
    send(1'b0, 4'd4, 8'd0,    {1'b0, 8'd0, 1'b1}, t0);
    send(1'b1, 4'd5, 8'h22,   {1'b1, 8'd0, 1'b1}, t0);
    send(1'b0, 4'd6, 8'd0,    {1'b0, 8'd0, 1'b1}, t0);
    send(1'b1, 4'd7, 8'h33,   {1'b1, 8'd0, 1'b1}, t0);
    @(negedge pclk);
    chk("full_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.rsp_valid) begin got = 1'b1; break; end
      @(negedge pclk);
    end
    chk("timeout_seen", 32'(got), 32'(1));
    chk("timeout_time", 32'($time - t1), 32'((TIMEOUT + 2) * 10 + 5));
    chk("timeout_next_setup", 32'({bus.psel, bus.penable}), 32'(2'b10));
    chk("timeout_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge pclk);
      if (bus.rsp_valid) begin got = 1'b1; break; end
    end
    chk("timeout2_seen", 32'(got), 32'(1));
    @(negedge pclk);
    chk("pre_rst_access", 32'({bus.psel, bus.penable}), 32'(2'b11));

    // asynchronous reset in ACCESS with two commands still queued
    #2 rst = 1'b1;
    #1;
    chk("arst_psel", 32'(bus.psel), 32'(0));
    chk("arst_penable", 32'(bus.penable), 32'(0));
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    exp_q.delete();
    hold_low = 1'b0;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    psel_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge pclk);
      if (bus.psel) psel_n++;
    end
    chk("post_rst_idle", 32'(psel_n), 32'(0));

    send(1'b1, 4'd9, 8'h77, {1'b1, 8'd0,   1'b0}, t0);
    send(1'b0, 4'd9, 8'd0,  {1'b0, 8'h77, 1'b0}, t0);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge pclk);
    @(negedge pclk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("final_rsp_count", 32'(rsp_cnt), 32'(8 + 4 + 2 + 2));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
